// File: rtl/dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_mem_arbiter
// Description : Two-port round-robin arbiter with bounded lock, sequencing
//               single-cycle accesses into a 16-byte DFF memory macro.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_mem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;        // 0 = A has priority, 1 = B
    logic               w_prio_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_rvalid_a;
    logic               r_rvalid_b;
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_cnt_last;

    // This grant in a locked state is the final one the lock allows.
    assign w_cnt_last = (r_cnt == c_CNT_W'(LOCK_MAX - 1));

    always_comb begin
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARB: begin
                if (req_a && (!req_b || !r_prio)) begin
                    w_gnt_a = 1'b1;
                end else if (req_b) begin
                    w_gnt_b = 1'b1;
                end
                if (w_gnt_a) begin
                    w_prio_nxt = 1'b1;
                    if (lock_a) begin
                        w_state_nxt = ST_LOCK_A;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_gnt_b) begin
                    w_prio_nxt = 1'b0;
                    if (lock_b) begin
                        w_state_nxt = ST_LOCK_B;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_LOCK_A: begin
                w_gnt_a = req_a;
                if (w_gnt_a) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
                if (!lock_a || (w_gnt_a && w_cnt_last)) begin
                    w_state_nxt = ST_ARB;
                    w_prio_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK_B: begin
                w_gnt_b = req_b;
                if (w_gnt_b) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
                if (!lock_b || (w_gnt_b && w_cnt_last)) begin
                    w_state_nxt = ST_ARB;
                    w_prio_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
        // No access may reach the memory while reset is held.
        if (rst) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w_gnt_a) begin
            mem_addr  = addr_a;
            mem_wdata = wdata_a;
            mem_we    = we_a;
        end else if (w_gnt_b) begin
            mem_addr  = addr_b;
            mem_wdata = wdata_b;
            mem_we    = we_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_prio     <= 1'b0;
            r_cnt      <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rvalid_a <= w_gnt_a && !we_a;
            r_rvalid_b <= w_gnt_b && !we_b;
        end
    end

    assign gnt_a    = w_gnt_a;
    assign gnt_b    = w_gnt_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata    = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dff_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_mem_arbiter
// Description : Scoreboard bench for dff_mem_arbiter with a behavioural
//               memory macro and a rule-level arbitration reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_mem_arbiter;

    localparam int c_LOCK_MAX = 4;

    logic       clk;
    logic       rst;
    logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    dff_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(c_LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .lock_a(lock_a), .lock_b(lock_b), .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory macro: registered read of the pre-write contents, reset with rst.
    logic [7:0] macro_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) macro_mem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) macro_mem[mem_addr] <= mem_wdata;
            mem_rdata <= macro_mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         port;
        logic [7:0] data;
        int         when;
    } exp_t;
    exp_t q[$];

    // Reference model: owner 0 = none, 1 = A, 2 = B; rr 0 = A favoured.
    int         m_owner = 0;
    int         m_rr    = 0;
    int         m_cnt   = 0;
    logic [7:0] ref_mem [16];
    logic       obs_ga, obs_gb, last_ea, last_eb;

    task automatic step(input logic r);
        logic       ea, eb, granted, lk;
        logic [3:0] ea_addr;
        logic [7:0] ea_data;
        logic       ea_we;
        exp_t       e;
        rst = r;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!r) begin
            if (m_owner == 1)       ea = req_a;
            else if (m_owner == 2)  eb = req_b;
            else if (req_a && req_b) begin
                if (m_rr == 0) ea = 1'b1; else eb = 1'b1;
            end else begin
                ea = req_a;
                eb = req_b;
            end
        end
        ea_addr = ea ? addr_a : (eb ? addr_b : 4'h0);
        ea_data = ea ? wdata_a : (eb ? wdata_b : 8'h00);
        ea_we   = ea ? we_a : (eb ? we_b : 1'b0);
        check("gnt_a", gnt_a, ea);
        check("gnt_b", gnt_b, eb);
        check("mem_we", mem_we, ea_we);
        check("mem_addr", mem_addr, ea_addr);
        check("mem_wdata", mem_wdata, ea_data);
        obs_ga = gnt_a;
        obs_gb = gnt_b;
        if (ea || eb) begin
            if (ea_we) ref_mem[ea_addr] = ea_data;
            else begin
                e.port = ea ? 0 : 1;
                e.data = ref_mem[ea_addr];
                e.when = cyc + 1;
                q.push_back(e);
            end
        end
        last_ea = ea;
        last_eb = eb;
        @(posedge clk);
        if (r) begin
            m_owner = 0; m_rr = 0; m_cnt = 0;
            for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        end else if (m_owner == 0) begin
            if (ea) begin
                m_rr = 1;
                if (lock_a) begin m_owner = 1; m_cnt = 0; end
            end else if (eb) begin
                m_rr = 0;
                if (lock_b) begin m_owner = 2; m_cnt = 0; end
            end
        end else begin
            granted = (m_owner == 1) ? ea : eb;
            lk      = (m_owner == 1) ? lock_a : lock_b;
            if (granted) m_cnt++;
            if (!lk || m_cnt == c_LOCK_MAX) begin
                m_rr    = (m_owner == 1) ? 1 : 0;
                m_owner = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_a(input logic r, input logic w, input logic l, input int a, input int d);
        req_a = r; we_a = w; lock_a = l; addr_a = 4'(a); wdata_a = 8'(d);
    endtask

    task automatic set_b(input logic r, input logic w, input logic l, input int a, input int d);
        req_b = r; we_b = w; lock_b = l; addr_b = 4'(a); wdata_b = 8'(d);
    endtask

    task automatic do_reset();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step(1'b1);
    endtask

    // Monitor: pops one expectation per returned read.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0 && q[0].when < cyc) begin
                e = q.pop_front();
                check("rvalid_missing", 32'(cyc), 32'(e.when));
            end
            if (rvalid_a || rvalid_b) begin
                if (q.size() == 0) begin
                    check("rvalid_unexpected", {rvalid_b, rvalid_a}, 2'b00);
                end else begin
                    e = q.pop_front();
                    check("rvalid_port", {rvalid_b, rvalid_a}, (e.port == 0) ? 2'b01 : 2'b10);
                    check("rvalid_cycle", 32'(cyc), 32'(e.when));
                    check("rdata", rdata, e.data);
                end
            end
        end
    end

    initial begin
        logic ga_seq [8];
        logic gb_seq [8];
        int   run;
        logic pa, pb, rr;
        rst = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        @(negedge clk);

        // Reset with requests pending: no grant, no write.
        set_a(1, 1, 1, 4, 8'h11);
        set_b(1, 1, 0, 5, 8'h22);
        step(1'b1);
        step(1'b1);
        check("rst_rvalid_a", rvalid_a, 1'b0);
        check("rst_rvalid_b", rvalid_b, 1'b0);

        // Single read after write.
        set_a(1, 1, 0, 3, 8'h5A); set_b(0, 0, 0, 0, 0); step(1'b0);
        set_a(0, 0, 0, 0, 0);     set_b(1, 0, 0, 3, 0);  step(1'b0);
        set_b(0, 0, 0, 0, 0);     step(1'b0);
        check("single_read_rdata_seen", ref_mem[3], 8'h5A);

        // Contention: alternating grants starting with A.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_a(1, 0, 0, 1, 0); set_b(1, 0, 0, 2, 0);
            step(1'b0);
            check("contend_order", {obs_gb, obs_ga}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Locked read-modify-write of addr 7 with B contending.
        do_reset();
        set_b(1, 1, 0, 7, 8'h30); step(1'b0);
        set_a(1, 0, 1, 7, 0); set_b(1, 0, 0, 2, 0); step(1'b0);
        set_a(1, 1, 0, 7, 32'(ref_mem[7]) + 1); step(1'b0);
        check("rmw_b_stalled", obs_gb, 1'b0);
        set_a(0, 0, 0, 0, 0); step(1'b0);
        check("rmw_b_after_release", obs_gb, 1'b1);
        set_b(1, 0, 0, 7, 0); step(1'b0);
        set_b(0, 0, 0, 0, 0); step(1'b0);
        check("rmw_value", ref_mem[7], 8'h31);

        // Lock timeout: 1 + LOCK_MAX grants, then B, then A again.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 1, i, 0); set_b(1, 0, 0, 9, 0);
            step(1'b0);
            ga_seq[i] = obs_ga;
            gb_seq[i] = obs_gb;
        end
        run = 0;
        while (run < 8 && ga_seq[run]) run++;
        check("timeout_a_run", 32'(run), 32'(1 + c_LOCK_MAX));
        check("timeout_b_next", gb_seq[1 + c_LOCK_MAX], 1'b1);
        check("timeout_a_resume", ga_seq[2 + c_LOCK_MAX], 1'b1);

        // Reset while locked with a read in flight.
        do_reset();
        set_a(1, 0, 1, 5, 0); set_b(0, 0, 0, 0, 0); step(1'b0);
        set_a(1, 0, 1, 6, 0); step(1'b0);
        set_b(1, 0, 0, 8, 0); step(1'b1);
        check("midlock_rvalid_a", rvalid_a, 1'b0);
        set_a(1, 0, 0, 5, 0); step(1'b0);
        check("midlock_first_grant_a", {obs_gb, obs_ga}, 2'b01);

        // Idle, then a lone write.
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); step(1'b0);
        set_a(1, 1, 0, 12, 8'hC3); step(1'b0);
        set_a(0, 0, 0, 0, 0); step(1'b0);
        check("write_no_rvalid", {rvalid_b, rvalid_a}, 2'b00);

        // Randomized traffic with requests held until granted.
        pa = 1'b0;
        pb = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!pa) begin
                if ($urandom_range(0, 2) != 0) begin
                    pa = 1'b1;
                    set_a(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 15), $urandom_range(0, 255));
                end else begin
                    req_a = 1'b0;
                    if ($urandom_range(0, 3) == 0) lock_a = ~lock_a;
                end
            end
            if (!pb) begin
                if ($urandom_range(0, 2) != 0) begin
                    pb = 1'b1;
                    set_b(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 15), $urandom_range(0, 255));
                end else begin
                    req_b = 1'b0;
                    if ($urandom_range(0, 3) == 0) lock_b = ~lock_b;
                end
            end
            rr = ($urandom_range(0, 79) == 0);
            step(rr);
            if (last_ea) pa = 1'b0;
            if (last_eb) pb = 1'b0;
        end

        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_mem_arbiter.md
# dff_mem_arbiter

Two-port round-robin arbiter and sequencer in front of the 16-byte DFF memory macro. Requesters A and B issue single-cycle read or write accesses; the arbiter grants at most one per cycle, drives the memory's address, data and write-enable, and returns read data to the winning requester. It supports a bounded lock so one requester can perform atomic read-modify-write sequences.

## Interface
- ADDR_W, 4: memory address width (16 bytes).
- DATA_W, 8: data width.
- LOCK_MAX, 4: maximum consecutive locked grants after the lock-opening grant.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_a / req_b  in  1  access request; held until granted.
- we_a / we_b  in  1  1 = write, 0 = read.
- lock_a / lock_b  in  1  request exclusive ownership after this grant.
- addr_a / addr_b  in  ADDR_W  byte address.
- wdata_a / wdata_b  in  DATA_W  write data.
- gnt_a / gnt_b  out  1  combinational; the access is performed this cycle.
- rvalid_a / rvalid_b  out  1  registered; rdata valid this cycle.
- rdata  out  DATA_W  shared read data; wired from mem_rdata.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_we  out  1  to memory write enable.
- mem_rdata  in  DATA_W  from memory registered output.

## Operation
- Grants are mutually exclusive. gnt_x is high only when req_x is high and state permits it.
- On a granted cycle, mem_addr, mem_wdata and mem_we equal the winner's addr, wdata and we.
- With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Round-robin pointer `prio`:
  - In ARB, if both request, the `prio` side wins.
  - After any grant in ARB, `prio` moves to the non-winner.
  - If one side requests, it wins regardless of `prio`.
- FSM states: ARB, LOCK_A, LOCK_B.
  - ARB -> LOCK_x: on a grant to x with lock_x=1. The lock counter loads 0.
  - LOCK_x: only x can be granted. gnt_x = req_x. The other side is stalled even if requesting.
  - Each granted cycle in LOCK_x increments the counter.
  - LOCK_x -> ARB: when lock_x=0 (sampled any cycle in LOCK_x), or when the counter reaches LOCK_MAX on a grant.
  - On any LOCK_x -> ARB exit, `prio` is set to the other side.
  - Idle cycles in LOCK_x (req_x=0, lock_x=1) keep the lock and do not advance the counter.
- Read return: a read grant to x sets rvalid_x for exactly one cycle on the next edge. rdata reflects mem_rdata in that cycle.
- Write return: write grants do not assert rvalid. The memory still updates its output register, but that value is ignored.
- Write and read to the same address in consecutive cycles: the read returns the new data. The memory reads the old value when read and write fall in the same cycle, but that case cannot occur because grants are exclusive.

## Timing
- Grant latency: 0 cycles; gnt is combinational from req and the registered state.
- Read data latency: 1 cycle after grant.
- Throughput: one access per cycle, back-to-back, with no bubbles, including alternating A/B.
- Reset (rst high at a clk edge):
  - state = ARB, prio = A, counter = 0, rvalid_a = rvalid_b = 0.
  - gnt_a, gnt_b and mem_we are 0 while rst is high.
- Reset during a lock or with a read in flight: the lock is dropped and the pending rvalid is suppressed. The memory is reset by its own logic on the same rst.
- No input is registered except as noted. Requesters must keep req and the access fields stable until their gnt cycle.

## Test plan
- Single read: write 0x5A to addr 3 via A, then read addr 3 via B. Required: gnt_b in the read cycle, rvalid_b one cycle later with rdata=0x5A, rvalid_a never high.
- Contention: A and B hold read requests for 4 cycles after reset. Required: grants alternate A,B,A,B, and each rvalid follows its own grant by one cycle.
- Lock RMW, LOCK_MAX=4: A reads addr 7 with lock_a=1, then writes addr 7 = old+1 while B requests continuously. Required: B not granted until lock_a falls; B granted in the first ARB cycle after the lock is released; a subsequent B read of addr 7 returns the incremented value.
- Lock timeout: A holds lock_a=1 and req_a=1 continuously. Required: A receives 1+LOCK_MAX consecutive grants, then B is granted, then A resumes.
- Reset mid-lock: assert rst while in LOCK_A with a read in flight. Required: rvalid_a=0 the next cycle, state is ARB, and the first contended grant after reset goes to A.
- Idle and write: no requests gives mem_we=0 and mem_addr=0. A write grant asserts mem_we for one cycle and produces no rvalid.
